fill_sequencer: RTL

- Sequencing controller for the pill-bottling datapath.
- Accepts a validated job (pills per bottle, bottle count, both BCD), counts pill pulses from the hopper edge detector, and requests a conveyor advance between bottles.
- Supervises hopper starvation and conveyor faults; emergency stop overrides everything.
- Sits between the settings/keypad logic and the display/buzzer logic. Its state encoding drives the status digit directly.

---
 rtl/fill_sequencer_if.sv | 60 ++++++
 rtl/fill_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fill_sequencer_if.sv
// -----------------------------------------------------------------------------
// fill_sequencer_if
// Handshake and data bundle between the pill-bottling controller and its
// neighbours (settings/keypad logic on the input side, display/buzzer logic
// on the output side).
//
// Signals:
//   start          one-cycle job start request
//   ack            one-cycle operator acknowledge
//   emergncy_stop  level, emergency stop
//   pill_edge      one-cycle pulse per pill dropped
//   conveyor_ok    level, conveyor running
//   pause          level, pause filling (only with FILL_PAUSE_EN)
//   target_pills   3 BCD digits, hundreds in [11:8]
//   target_bottles 2 BCD digits, tens in [7:4]
//   now_pills      BCD pills in the current bottle
//   now_bottles    BCD bottles completed
//   state          controller state (drives the status digit)
//   switch_req     one-cycle conveyor advance pulse
//   fault_code     0 none, 1 hopper, 2 conveyor, 3 emergency
//
// Modports: master drives the requests and watches the status,
//           slave is the controller side.
// Optional macro: FILL_PAUSE_EN adds the pause signal.
// -----------------------------------------------------------------------------
interface fill_sequencer_if;
   logic        start;
   logic        ack;
   logic        emergncy_stop;
   logic        pill_edge;
   logic        conveyor_ok;
`ifdef FILL_PAUSE_EN
   logic        pause;
`endif
   logic [11:0] target_pills;
   logic [7:0]  target_bottles;
   logic [11:0] now_pills;
   logic [7:0]  now_bottles;
   logic [2:0]  state;
   logic        switch_req;
   logic [1:0]  fault_code;

   modport master (
      output start, ack, emergncy_stop, pill_edge, conveyor_ok,
`ifdef FILL_PAUSE_EN
      output pause,
`endif
      output target_pills, target_bottles,
      input  now_pills, now_bottles, state, switch_req, fault_code
   );

   modport slave (
      input  start, ack, emergncy_stop, pill_edge, conveyor_ok,
`ifdef FILL_PAUSE_EN
      input  pause,
`endif
      input  target_pills, target_bottles,
      output now_pills, now_bottles, state, switch_req, fault_code
   );
endinterface

// File: rtl/fill_sequencer.sv
// -----------------------------------------------------------------------------
// fill_sequencer
// Sequencing controller for the pill-bottling datapath. Accepts a validated
// BCD job, counts pill pulses, requests a conveyor advance between bottles,
// and supervises hopper starvation and conveyor faults. Emergency stop
// overrides everything.
//
// Ports:
//   clk_1khz    system clock
//   switch_clr  asynchronous active-low reset
//   bus         fill_sequencer_if.slave (requests, targets, counts, status)
//
// Parameters:
//   TICK_DIV    clock cycles per timer tick
//   SWITCH_SEC  bottle-switch dwell in ticks (1..15)
//   HOPPER_SEC  hopper watchdog timeout in ticks (1..15)
//
// Optional macro: FILL_PAUSE_EN adds a pause input and the PAUSED state (6).
// -----------------------------------------------------------------------------
module fill_sequencer #(
   parameter int unsigned TICK_DIV   = 1000,
   parameter int unsigned SWITCH_SEC = 2,
   parameter int unsigned HOPPER_SEC = 5
) (
   input logic             clk_1khz,
   input logic             switch_clr,
   fill_sequencer_if.slave bus
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
   localparam logic [3:0] SWITCH_LOAD = 4'(SWITCH_SEC);
   localparam logic [3:0] HOPPER_LOAD = 4'(HOPPER_SEC);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FILLING   = 3'd1,
      S_SWITCHING = 3'd2,
      S_DONE      = 3'd3,
      S_ERROR     = 3'd4,
      S_FATAL     = 3'd5
`ifdef FILL_PAUSE_EN
      , S_PAUSED  = 3'd6
`endif
   } state_t;

   // Ripple BCD increment over three digits; 999 wraps to 000.
   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [11:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int unsigned d = 0; d < 3; d++) begin
         if (carry) begin
            if (r[d*4 +: 4] == 4'd9) begin
               r[d*4 +: 4] = 4'd0;
            end else begin
               r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic digits_ok(input logic [11:0] v);
      logic ok;
      ok = 1'b1;
      for (int unsigned d = 0; d < 3; d++) begin
         if (v[d*4 +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   state_t        state_q;
   logic [11:0]   pills_q;
   logic [7:0]    bottles_q;
   logic [11:0]   tgt_pills_q;
   logic [7:0]    tgt_bottles_q;
   logic [1:0]    fault_q;
   logic          switch_req_q;
   logic [PW-1:0] pre_q;
   logic [3:0]    secs_q;

   logic          pause_req;
   logic          tick;
   logic          expire;
   logic          timer_run;
   logic          targets_ok;
   logic [11:0]   pills_inc;
   logic [11:0]   bottles_wide;
   logic          pill_hit;
   logic          bottle_hit;
   logic          pill_take;

`ifdef FILL_PAUSE_EN
   assign pause_req = bus.pause;
`else
   assign pause_req = 1'b0;
`endif

   always_comb begin
      tick         = (pre_q == PRE_MAX);
      expire       = tick && (secs_q == 4'd1);
      // Pausing freezes the timer in the same cycle, so resume continues
      // from exactly where it stopped.
      timer_run    = ((state_q == S_FILLING) && !pause_req) ||
                     (state_q == S_SWITCHING);
      targets_ok   = digits_ok(bus.target_pills) &&
                     digits_ok({4'h0, bus.target_bottles}) &&
                     (bus.target_pills != 12'h000) &&
                     (bus.target_bottles != 8'h00);
      pills_inc    = bcd_inc(pills_q);
      bottles_wide = bcd_inc({4'h0, bottles_q});
      pill_hit     = (pills_inc == tgt_pills_q);
      bottle_hit   = (bottles_wide == {4'h0, tgt_bottles_q});
      // A counted pill in FILLING, or the pill that clears a hopper fault.
      // ack in ERROR takes precedence over the resume.
      pill_take    = bus.pill_edge &&
                     (((state_q == S_FILLING) && !pause_req) ||
                      ((state_q == S_ERROR) && (fault_q == 2'd1) && !bus.ack));
   end

   always_ff @(posedge clk_1khz or negedge switch_clr) begin
      if (!switch_clr) begin
         state_q       <= S_IDLE;
         pills_q       <= '0;
         bottles_q     <= '0;
         tgt_pills_q   <= '0;
         tgt_bottles_q <= '0;
         fault_q       <= '0;
         switch_req_q  <= 1'b0;
         pre_q         <= '0;
         secs_q        <= '0;
      end else begin
         switch_req_q <= 1'b0;

         if (timer_run) begin
            if (tick) begin
               pre_q  <= '0;
               secs_q <= secs_q - 4'd1;
            end else begin
               pre_q <= pre_q + PW'(1);
            end
         end

         if (bus.emergncy_stop) begin
            state_q <= S_FATAL;
            fault_q <= 2'd3;
         end else if (pill_take) begin
            // Pill wins over a same-cycle watchdog expiry; loads below
            // override the timer update above.
            pills_q <= pills_inc;
            fault_q <= 2'd0;
            pre_q   <= '0;
            secs_q  <= HOPPER_LOAD;
            if (pill_hit) begin
               bottles_q <= bottles_wide[7:0];
               if (bottle_hit) begin
                  state_q <= S_DONE;
               end else begin
                  state_q      <= S_SWITCHING;
                  switch_req_q <= 1'b1;
                  secs_q       <= SWITCH_LOAD;
               end
            end else begin
               state_q <= S_FILLING;
            end
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (bus.start) begin
                     tgt_pills_q   <= bus.target_pills;
                     tgt_bottles_q <= bus.target_bottles;
                     if (targets_ok) begin
                        pills_q   <= '0;
                        bottles_q <= '0;
                        fault_q   <= 2'd0;
                        pre_q     <= '0;
                        secs_q    <= HOPPER_LOAD;
                        state_q   <= S_FILLING;
                     end
                  end
               end
               S_FILLING: begin
                  if (pause_req) begin
`ifdef FILL_PAUSE_EN
                     state_q <= S_PAUSED;
`endif
                  end else if (expire) begin
                     state_q <= S_ERROR;
                     fault_q <= 2'd1;
                  end
               end
               S_SWITCHING: begin
                  if (expire) begin
                     if (bus.conveyor_ok) begin
                        pills_q <= '0;
                        pre_q   <= '0;
                        secs_q  <= HOPPER_LOAD;
                        state_q <= S_FILLING;
                     end else begin
                        state_q <= S_ERROR;
                        fault_q <= 2'd2;
                     end
                  end
               end
               S_ERROR: begin
                  if (bus.ack) begin
                     state_q <= S_IDLE;
                  end else if ((fault_q == 2'd2) && bus.conveyor_ok) begin
                     pills_q <= '0;
                     pre_q   <= '0;
                     secs_q  <= HOPPER_LOAD;
                     fault_q <= 2'd0;
                     state_q <= S_FILLING;
                  end
               end
               S_DONE: begin
                  if (bus.ack) state_q <= S_IDLE;
               end
               S_FATAL: begin
                  // Only reached here with emergncy_stop low.
                  if (bus.ack) begin
                     state_q <= S_IDLE;
                     fault_q <= 2'd0;
                  end
               end
`ifdef FILL_PAUSE_EN
               S_PAUSED: begin
                  if (bus.ack) begin
                     state_q <= S_IDLE;
                  end else if (!bus.pause) begin
                     state_q <= S_FILLING;
                  end
               end
`endif
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.now_pills   = pills_q;
   assign bus.now_bottles = bottles_q;
   assign bus.state       = state_q;
   assign bus.switch_req  = switch_req_q;
   assign bus.fault_code  = fault_q;

endmodule
